// File: rtl/l1_dcache_if.sv
// Core/memory handshake bundle for the L1 data cache.
// slave  : the cache's view (takes core requests, issues memory line requests)
// master : the environment's view (core + memory model)
interface l1_dcache_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 cache with 4-word lines.
// Hits complete with zero wait; misses stall the core while a dirty victim
// is written back (WRITEBACK) and the line is refilled (ALLOCATE).
// Optional build macro CACHE_STATS_EN adds hit_cnt/miss_cnt output counters.
module l1_dcache #(
  parameter  int INDEX_W = 3,
  localparam int TAG_W   = 30 - 2 - INDEX_W,
  localparam int LINES   = 1 << INDEX_W
) (
  input logic clk,
  input logic rst_n,
  l1_dcache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tag_arr [LINES];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] idx;
  logic [1:0]         off;
  logic               req;
  logic               hit;
  logic               read_hit;
  logic               write_hit;
  logic               fill_en;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic [31:0]        word_rd [4];
  logic [127:0]       line;

  assign {req_tag, idx, off} = bus.proc_addr;
  assign req       = bus.proc_read | bus.proc_write;
  assign hit       = valid[idx] && (tag_arr[idx] == req_tag);
  // A simultaneous read+write is a write, so it never returns read data.
  assign read_hit  = (state == IDLE) && bus.proc_read && !bus.proc_write && hit;
  assign write_hit = (state == IDLE) && bus.proc_write && hit;

  // The refill target comes from the registered line address rather than the
  // live core address, so a misbehaving core cannot tear a line apart.
  assign fill_en  = (state == ALLOCATE) && bus.mem_ready;
  assign fill_idx = bus.mem_addr[INDEX_W-1:0];
  assign fill_tag = bus.mem_addr[27:INDEX_W];

  assign line           = {word_rd[3], word_rd[2], word_rd[1], word_rd[0]};
  assign bus.proc_rdata = read_hit ? word_rd[off] : 32'd0;
  assign bus.proc_stall = (state != IDLE) || (req && !hit);

  // One 32-bit bank per word position; a write hit touches one bank only.
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    logic [31:0] bank [LINES];

    // Refill whole line from memory, otherwise merge a core write hit.
    always_ff @(posedge clk) begin
      if (fill_en) begin
        bank[fill_idx] <= bus.mem_rdata[32*gi +: 32];
      end else if (write_hit && (off == 2'(gi))) begin
        bank[idx] <= bus.proc_wdata;
      end
    end

    assign word_rd[gi] = bank[idx];
  end

  // Tag array is only written on refill; it needs no reset since valid gates it.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_arr[fill_idx] <= fill_tag;
    end
  end

  // Miss-handling FSM with registered memory request outputs and line status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_hit) begin
            dirty[idx] <= 1'b1;
          end else if (req && !hit) begin
            if (valid[idx] && dirty[idx]) begin
              state         <= WRITEBACK;
              bus.mem_write <= 1'b1;
              bus.mem_addr  <= {tag_arr[idx], idx};
              bus.mem_wdata <= line;
            end else begin
              state        <= ALLOCATE;
              bus.mem_read <= 1'b1;
              bus.mem_addr <= {req_tag, idx};
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) begin
            state         <= ALLOCATE;
            bus.mem_write <= 1'b0;
            bus.mem_read  <= 1'b1;
            bus.mem_addr  <= {req_tag, idx};
          end
        end
        ALLOCATE: begin
          if (bus.mem_ready) begin
            state           <= IDLE;
            bus.mem_read    <= 1'b0;
            valid[fill_idx] <= 1'b1;
            dirty[fill_idx] <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // The first IDLE cycle after a refill is the stalled access finishing, which
  // is already counted as a miss, so it is not counted again as a hit.
  logic replay;

  // Hit/miss event counters, free-running and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      replay   <= 1'b0;
    end else begin
      replay <= fill_en;
      if ((state == IDLE) && req) begin
        if (hit && !replay) begin
          hit_cnt <= hit_cnt + 32'd1;
        end
        if (!hit) begin
          miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed corner cases, a table of hit
// vectors, then random traffic against a flat-memory reference model.
// Build with +define+CACHE_STATS_EN to also exercise the statistics counters.
`timescale 1ns/1ps
module tb_l1_dcache;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1_dcache_if bus();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  l1_dcache dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int lat = 5;
  int cyc = 0;
  logic spur_ready = 1'b0;

  // Backing memory (line granular) and core-visible word image.
  logic [127:0] mem_store [logic [27:0]];
  logic [31:0]  ref_mem   [logic [29:0]];

  // Which line each index holds, from the direct-mapped placement rule.
  logic        mv [8];
  logic        md [8];
  logic [24:0] mt [8];

  typedef struct {
    logic        wr;
    logic [27:0] addr;
    logic [127:0] data;
  } mreq_t;
  mreq_t mlog[$];
  int both_high = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  typedef struct {
    logic        wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_stall;
  } vec_t;
  vec_t vecs[6];

  always @(posedge clk) cyc++;

  function automatic logic [31:0] word_init(input logic [29:0] a);
    return {a, 2'b00} ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [127:0] backing_line(input logic [27:0] la);
    logic [127:0] l;
    if (mem_store.exists(la)) return mem_store[la];
    for (int w = 0; w < 4; w++) l[32*w +: 32] = word_init({la, 2'(w)});
    return l;
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] a);
    logic [127:0] l;
    if (ref_mem.exists(a)) return ref_mem[a];
    l = backing_line(a[29:2]);
    return l[32*a[1:0] +: 32];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers each request after lat waiting cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      if (!rst_n) begin
        wait_cnt = 0;
      end else if (bus.mem_read || bus.mem_write) begin
        if (wait_cnt >= lat) begin
          bus.mem_ready = 1'b1;
          wait_cnt = 0;
          if (bus.mem_write) mem_store[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = backing_line(bus.mem_addr);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        bus.mem_ready = spur_ready;
        if (spur_ready) bus.mem_rdata = {4{32'hBAD0_BAD0}};
      end
    end
  end

  // Records each new memory request and any overlap of read and write.
  always @(negedge clk) begin
    if (bus.mem_read && bus.mem_write) both_high++;
    if (bus.mem_write && !prev_wr) mlog.push_back('{1'b1, bus.mem_addr, bus.mem_wdata});
    if (bus.mem_read && !prev_rd) mlog.push_back('{1'b0, bus.mem_addr, 128'd0});
    prev_wr = bus.mem_write;
    prev_rd = bus.mem_read;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ref_mem.delete();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.proc_read = 1'b0;
    bus.proc_write = 1'b0;
  endtask

  // Presents one access and waits (bounded) until the cache accepts it.
  task automatic do_access(input logic wr, input logic [29:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int stalls);
    @(negedge clk);
    bus.proc_read = !wr;
    bus.proc_write = wr;
    bus.proc_addr = a;
    bus.proc_wdata = wd;
    stalls = 0;
    #1;
    while (bus.proc_stall !== 1'b0 && stalls < 500) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    chk("no_deadlock", 128'(stalls >= 500), 128'd0);
    rd = bus.proc_rdata;
    $display("txn %s addr=%h wdata=%h rdata=%h stalls=%0d", wr ? "WR" : "RD", a, wd, rd, stalls);
  endtask

  initial begin
    logic [31:0] rd;
    int st;
    int prev_cyc;
    int n;
    logic [127:0] exp_line;

    vecs[0] = '{1'b0, 30'h4, 32'h0, 32'h1111_1111, 0};
    vecs[1] = '{1'b0, 30'h5, 32'h0, 32'hDEAD_BEEF, 0};
    vecs[2] = '{1'b0, 30'h6, 32'h0, 32'h3333_3333, 0};
    vecs[3] = '{1'b0, 30'h7, 32'h0, 32'h4444_4444, 0};
    vecs[4] = '{1'b1, 30'h6, 32'hCAFE_F00D, 32'h0, 0};
    vecs[5] = '{1'b0, 30'h6, 32'h0, 32'hCAFE_F00D, 0};

    bus.proc_read = 1'b0;
    bus.proc_write = 1'b0;
    bus.proc_addr = '0;
    bus.proc_wdata = '0;

    // Reset state
    rst_n = 1'b0;
    #12;
    chk("rst_stall", 128'(bus.proc_stall), 128'd0);
    chk("rst_mem_read", 128'(bus.mem_read), 128'd0);
    chk("rst_mem_write", 128'(bus.mem_write), 128'd0);
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 128'd0);
    chk("rst_rdata", 128'(bus.proc_rdata), 128'd0);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h5;
    #1;
    chk("rst_stall_on_req", 128'(bus.proc_stall), 128'd1);
    bus.proc_read = 1'b0;
    do_reset();

    // Cold read miss
    lat = 5;
    mem_store[28'h1] = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    mlog.delete();
    do_access(1'b0, 30'h5, 32'h0, rd, st);
    chk("cold_stalls", 128'(st), 128'd7);
    chk("cold_rdata", 128'(rd), 128'h2222_2222);
    chk("cold_nreq", 128'(mlog.size()), 128'd1);
    if (mlog.size() >= 1) begin
      chk("cold_req_kind", 128'(mlog[0].wr), 128'd0);
      chk("cold_req_addr", 128'(mlog[0].addr), 128'h1);
    end

    // Write hit, then dirty eviction
    do_access(1'b1, 30'h5, 32'hDEAD_BEEF, rd, st);
    chk("wrhit_stalls", 128'(st), 128'd0);
    mlog.delete();
    do_access(1'b0, 30'h2000_0005, 32'h0, rd, st);
    chk("evict_stalls", 128'(st), 128'd13);
    chk("evict_rdata", 128'(rd), 128'(word_init(30'h2000_0005)));
    chk("evict_nreq", 128'(mlog.size()), 128'd2);
    if (mlog.size() >= 2) begin
      chk("evict_wb_kind", 128'(mlog[0].wr), 128'd1);
      chk("evict_wb_addr", 128'(mlog[0].addr), 128'h1);
      chk("evict_wb_data", mlog[0].data, 128'h4444_4444_3333_3333_DEAD_BEEF_1111_1111);
      chk("evict_rd_kind", 128'(mlog[1].wr), 128'd0);
      chk("evict_rd_addr", 128'(mlog[1].addr), 128'h800_0001);
    end

    // Clean eviction: only a refill
    mlog.delete();
    do_access(1'b0, 30'h5, 32'h0, rd, st);
    chk("clean_stalls", 128'(st), 128'd7);
    chk("clean_rdata", 128'(rd), 128'hDEAD_BEEF);
    chk("clean_nreq", 128'(mlog.size()), 128'd1);
    if (mlog.size() >= 1) chk("clean_req_kind", 128'(mlog[0].wr), 128'd0);

    // Back-to-back hits from the vector table
    prev_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, st);
      chk($sformatf("vec%0d_stalls", i), 128'(st), 128'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vecs[i].exp_rd));
      if (i > 0) chk($sformatf("vec%0d_cycle", i), 128'(cyc - prev_cyc), 128'd1);
      prev_cyc = cyc;
    end
    go_idle();

    // Spurious mem_ready while idle must be ignored
    mlog.delete();
    @(negedge clk);
    spur_ready = 1'b1;
    repeat (2) @(negedge clk);
    spur_ready = 1'b0;
    do_access(1'b0, 30'h6, 32'h0, rd, st);
    chk("spur_stalls", 128'(st), 128'd0);
    chk("spur_rdata", 128'(rd), 128'hCAFE_F00D);
    chk("spur_nreq", 128'(mlog.size()), 128'd0);
    go_idle();

    // Reset in the middle of a writeback (line 1 is dirty)
    mlog.delete();
    @(negedge clk);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h2000_0004;
    n = 0;
    while (bus.mem_write !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_wb_seen", 128'(bus.mem_write), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_write", 128'(bus.mem_write), 128'd0);
    chk("midrst_mem_read", 128'(bus.mem_read), 128'd0);
    chk("midrst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("midrst_stall", 128'(bus.proc_stall), 128'd1);
    @(negedge clk);
    bus.proc_read = 1'b0;
    do_reset();
    mlog.delete();
    do_access(1'b0, 30'h2000_0004, 32'h0, rd, st);
    chk("postrst_stalls", 128'(st), 128'd7);
    chk("postrst_rdata", 128'(rd), 128'(word_init(30'h2000_0004)));
    chk("postrst_nreq", 128'(mlog.size()), 128'd1);
    if (mlog.size() >= 1) begin
      chk("postrst_kind", 128'(mlog[0].wr), 128'd0);
      chk("postrst_addr", 128'(mlog[0].addr), 128'h800_0001);
    end
    go_idle();

`ifdef CACHE_STATS_EN
    // Statistics: miss, hit, hit, miss
    do_reset();
    lat = 2;
    chk("stats_rst_hit", 128'(hit_cnt), 128'd0);
    chk("stats_rst_miss", 128'(miss_cnt), 128'd0);
    do_access(1'b0, 30'h10, 32'h0, rd, st);
    do_access(1'b0, 30'h11, 32'h0, rd, st);
    do_access(1'b0, 30'h12, 32'h0, rd, st);
    do_access(1'b0, 30'h2000_0010, 32'h0, rd, st);
    go_idle();
    @(negedge clk);
    chk("stats_hit", 128'(hit_cnt), 128'd2);
    chk("stats_miss", 128'(miss_cnt), 128'd2);
`endif

    // Random traffic against the reference model
    do_reset();
    for (int t = 0; t < 300; t++) begin
      logic        wr;
      logic [24:0] tag;
      logic [2:0]  ix;
      logic [1:0]  of;
      logic [29:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        is_hit;
      logic        is_dirty;
      int          exp_st;
      int          ts;

      lat = $urandom_range(1, 4);
      wr = ($urandom_range(0, 9) < 4);
      ts = $urandom_range(0, 2);
      tag = (ts == 0) ? 25'h0 : (ts == 1) ? 25'h1 : 25'h155_5555;
      ix = 3'($urandom_range(0, 7));
      of = 2'($urandom_range(0, 3));
      a = {tag, ix, of};
      wd = $urandom;

      is_hit = mv[ix] && (mt[ix] == tag);
      is_dirty = mv[ix] && md[ix];
      exp_st = is_hit ? 0 : (is_dirty ? 2 * lat + 3 : lat + 2);
      exp_rd = wr ? 32'd0 : ref_word(a);
      for (int w = 0; w < 4; w++) exp_line[32*w +: 32] = ref_word({mt[ix], ix, 2'(w)});

      mlog.delete();
      do_access(wr, a, wd, rd, st);
      chk("rand_stalls", 128'(st), 128'(exp_st));
      chk("rand_rdata", 128'(rd), 128'(exp_rd));
      if (!is_hit) begin
        chk("rand_nreq", 128'(mlog.size()), is_dirty ? 128'd2 : 128'd1);
        if (is_dirty && mlog.size() == 2) begin
          chk("rand_wb_addr", 128'(mlog[0].addr), 128'({mt[ix], ix}));
          chk("rand_wb_data", mlog[0].data, exp_line);
        end
        if (mlog.size() >= 1) chk("rand_fill_addr", 128'(mlog[mlog.size()-1].addr), 128'({tag, ix}));
        mv[ix] = 1'b1;
        mt[ix] = tag;
        md[ix] = wr;
      end else if (wr) begin
        md[ix] = 1'b1;
      end
      if (wr) ref_mem[a] = wd;
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    chk("never_both_req", 128'(both_high), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
